// File: rtl/nes_loader_pkg.sv
// Shared types and constants for the iNES cartridge loader.
package nes_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_HEADER     = 3'd1,
    ST_TRAINER    = 3'd2,
    ST_PRG        = 3'd3,
    ST_PRG_MIRROR = 3'd4,
    ST_CHR        = 3'd5,
    ST_DONE       = 3'd6,
    ST_ERROR      = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_MAGIC  = 2'b01,
    ERR_SIZE   = 2'b10,
    ERR_MAPPER = 2'b11
  } err_code_t;

  localparam logic [31:0] INES_MAGIC     = 32'h4E45531A;
  localparam logic [3:0]  HDR_LAST_IDX   = 4'hF;
  localparam logic [14:0] PRG_16K_LAST   = 15'h3FFF;
  localparam logic [14:0] PRG_32K_LAST   = 15'h7FFF;
  localparam logic [15:0] PRG_MIRROR_OFS = 16'h4000;
  localparam logic [12:0] CHR_8K_LAST    = 13'h1FFF;

  // Expected magic byte for header positions 0..3 ("NES" followed by EOF).
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return INES_MAGIC[31:24];
      2'd1:    return INES_MAGIC[23:16];
      2'd2:    return INES_MAGIC[15:8];
      2'd3:    return INES_MAGIC[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ines_header_check.sv
// Watches header beats: flags a bad magic byte on the beat itself and
// captures the size/flag fields so the loader can judge them after byte 15.
module ines_header_check
  import nes_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       beat,
  input  logic [3:0] idx,
  input  logic [7:0] hdr_byte,
  output logic       magic_err,
  output logic [7:0] prg_banks,
  output logic [7:0] chr_banks,
  output logic       trainer,
  output logic       mirroring,
  output logic [7:0] mapper
);

  logic [7:0] prg_banks_r;
  logic [7:0] chr_banks_r;
  logic       trainer_r;
  logic       mirroring_r;
  logic [3:0] mapper_lo_r;
  logic [3:0] mapper_hi_r;
  logic       magic_err_s;

  // Magic mismatch is reported on the beat so the loader can stop at once.
  always_comb begin
    magic_err_s = 1'b0;
    if (beat && (idx < 4'd4)) begin
      magic_err_s = (hdr_byte != magic_byte(idx[1:0]));
    end else begin
      magic_err_s = 1'b0;
    end
  end

  // Capture header fields from bytes 4..7; cleared whenever a new load starts.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      prg_banks_r <= 8'h00;
      chr_banks_r <= 8'h00;
      trainer_r   <= 1'b0;
      mirroring_r <= 1'b0;
      mapper_lo_r <= 4'h0;
      mapper_hi_r <= 4'h0;
    end else if (beat) begin
      case (idx)
        4'd4: prg_banks_r <= hdr_byte;
        4'd5: chr_banks_r <= hdr_byte;
        4'd6: begin
          mirroring_r <= hdr_byte[0];
          trainer_r   <= hdr_byte[2];
          mapper_lo_r <= hdr_byte[7:4];
        end
        4'd7: mapper_hi_r <= hdr_byte[7:4];
        default: ;
      endcase
    end
  end

  assign magic_err = magic_err_s;
  assign prg_banks = prg_banks_r;
  assign chr_banks = chr_banks_r;
  assign trainer   = trainer_r;
  assign mirroring = mirroring_r;
  assign mapper    = {mapper_hi_r, mapper_lo_r};

endmodule

// File: rtl/ines_rom_loader.sv
// iNES stream loader: validates the header, writes PRG (mirroring 16KB images
// into both halves) and CHR, and holds the CPU in reset until a load succeeds.
module ines_rom_loader
  import nes_loader_pkg::*;
#(
  parameter logic [15:0] PRG_BASE      = 16'h8000,
  parameter int          TRAINER_BYTES = 512,
  parameter int          MAX_PRG_BANKS = 2,
  parameter int          MAX_CHR_BANKS = 1
) (
  input  logic        ROM_CLK,
  input  logic        RESET_n,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        prgmr_wren,
  output logic [15:0] prgmr_addr,
  output logic [7:0]  prgmr_data,
  output logic        chr_wren,
  output logic [12:0] chr_addr,
  output logic [7:0]  chr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [1:0]  error_code,
  output logic        mirroring
);

  state_t      state_r, next_state_s;
  logic [14:0] cnt_r, cnt_s;
  logic        in_ready_r, prg_wren_r, prg_wren_s, chr_wren_r, chr_wren_s;
  logic [15:0] prg_addr_r, prg_addr_s;
  logic [7:0]  prg_data_r, prg_data_s, chr_data_r, chr_data_s;
  logic [12:0] chr_addr_r, chr_addr_s;
  logic        done_r, done_s, error_r, error_s, hold_r, hold_s;
  err_code_t   code_r, code_s;

  logic        beat_s, start_ok_s, magic_err_s, trainer_s, mirroring_s;
  logic [7:0]  prg_banks_s, chr_banks_s, mapper_s;
  logic        size_err_s, mapper_err_s, one_bank_s, has_chr_s, prg_last_s;
  state_t      after_prg_s;

  assign beat_s       = in_valid && in_ready_r;
  assign start_ok_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR));
  assign size_err_s   = (prg_banks_s == 8'd0) || (prg_banks_s > 8'(MAX_PRG_BANKS)) ||
                        (chr_banks_s > 8'(MAX_CHR_BANKS));
  assign mapper_err_s = (mapper_s != 8'h00);
  assign one_bank_s   = (prg_banks_s == 8'd1);
  assign has_chr_s    = (chr_banks_s != 8'd0);
  assign prg_last_s   = (cnt_r == (one_bank_s ? PRG_16K_LAST : PRG_32K_LAST));
  assign after_prg_s  = has_chr_s ? ST_CHR : ST_DONE;

  ines_header_check u_hdr (
    .clk       (ROM_CLK),
    .rst_n     (RESET_n),
    .clear     (start_ok_s),
    .beat      (beat_s && (state_r == ST_HEADER)),
    .idx       (cnt_r[3:0]),
    .hdr_byte  (in_data),
    .magic_err (magic_err_s),
    .prg_banks (prg_banks_s),
    .chr_banks (chr_banks_s),
    .trainer   (trainer_s),
    .mirroring (mirroring_s),
    .mapper    (mapper_s)
  );

  // State register.
  always_ff @(posedge ROM_CLK) begin
    if (!RESET_n) state_r <= ST_IDLE;
    else          state_r <= next_state_s;
  end

  // Next-state decision for each load phase.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: next_state_s = start ? ST_HEADER : state_r;
      ST_HEADER: begin
        if (!beat_s)                     next_state_s = ST_HEADER;
        else if (magic_err_s)            next_state_s = ST_ERROR;
        else if (cnt_r[3:0] != HDR_LAST_IDX) next_state_s = ST_HEADER;
        else if (size_err_s || mapper_err_s) next_state_s = ST_ERROR;
        else if (trainer_s)              next_state_s = ST_TRAINER;
        else                             next_state_s = ST_PRG;
      end
      ST_TRAINER: next_state_s = (beat_s && (cnt_r == 15'(TRAINER_BYTES - 1))) ? ST_PRG : ST_TRAINER;
      ST_PRG: begin
        if (!beat_s)         next_state_s = ST_PRG;
        else if (one_bank_s) next_state_s = ST_PRG_MIRROR;
        else if (prg_last_s) next_state_s = after_prg_s;
        else                 next_state_s = ST_PRG;
      end
      ST_PRG_MIRROR: next_state_s = prg_last_s ? after_prg_s : ST_PRG;
      ST_CHR:  next_state_s = (beat_s && (cnt_r[12:0] == CHR_8K_LAST)) ? ST_DONE : ST_CHR;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Counter, write strobes and status values for the next cycle.
  always_comb begin
    cnt_s      = cnt_r;
    prg_wren_s = 1'b0;
    prg_addr_s = prg_addr_r;
    prg_data_s = prg_data_r;
    chr_wren_s = 1'b0;
    chr_addr_s = chr_addr_r;
    chr_data_s = chr_data_r;
    done_s     = done_r;
    error_s    = error_r;
    code_s     = code_r;
    hold_s     = hold_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          cnt_s   = 15'd0;
          done_s  = 1'b0;
          error_s = 1'b0;
          code_s  = ERR_NONE;
          hold_s  = 1'b1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_HEADER: begin
        if (beat_s) begin
          cnt_s = (cnt_r[3:0] == HDR_LAST_IDX) ? 15'd0 : cnt_r + 15'd1;
          if (magic_err_s)                                code_s = ERR_MAGIC;
          else if ((cnt_r[3:0] == HDR_LAST_IDX) && size_err_s)   code_s = ERR_SIZE;
          else if ((cnt_r[3:0] == HDR_LAST_IDX) && mapper_err_s) code_s = ERR_MAPPER;
          else                                            code_s = code_r;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_TRAINER: begin
        if (beat_s) cnt_s = (cnt_r == 15'(TRAINER_BYTES - 1)) ? 15'd0 : cnt_r + 15'd1;
        else        cnt_s = cnt_r;
      end
      ST_PRG: begin
        if (beat_s) begin
          prg_wren_s = 1'b1;
          prg_addr_s = PRG_BASE + {1'b0, cnt_r};
          prg_data_s = in_data;
          // A 16KB image advances the counter only after its mirror write.
          if (one_bank_s) cnt_s = cnt_r;
          else            cnt_s = prg_last_s ? 15'd0 : cnt_r + 15'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_PRG_MIRROR: begin
        prg_wren_s = 1'b1;
        prg_addr_s = PRG_BASE + {1'b0, cnt_r} + PRG_MIRROR_OFS;
        cnt_s      = prg_last_s ? 15'd0 : cnt_r + 15'd1;
      end
      ST_CHR: begin
        if (beat_s) begin
          chr_wren_s = 1'b1;
          chr_addr_s = cnt_r[12:0];
          chr_data_s = in_data;
          cnt_s      = (cnt_r[12:0] == CHR_8K_LAST) ? 15'd0 : cnt_r + 15'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: cnt_s = 15'd0;
    endcase
    error_s = error_s || ((next_state_s == ST_ERROR) && (state_r != ST_ERROR));
    done_s  = done_s  || ((next_state_s == ST_DONE) && (state_r != ST_DONE));
    hold_s  = hold_s  && !((next_state_s == ST_DONE) && (state_r != ST_DONE));
  end

  // Output and counter registers.
  always_ff @(posedge ROM_CLK) begin
    if (!RESET_n) begin
      cnt_r      <= 15'd0;
      in_ready_r <= 1'b0;
      prg_wren_r <= 1'b0;
      prg_addr_r <= 16'h0000;
      prg_data_r <= 8'h00;
      chr_wren_r <= 1'b0;
      chr_addr_r <= 13'h0000;
      chr_data_r <= 8'h00;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      code_r     <= ERR_NONE;
      hold_r     <= 1'b1;
    end else begin
      cnt_r      <= cnt_s;
      in_ready_r <= (next_state_s == ST_HEADER) || (next_state_s == ST_TRAINER) ||
                    (next_state_s == ST_PRG)    || (next_state_s == ST_CHR);
      prg_wren_r <= prg_wren_s;
      prg_addr_r <= prg_addr_s;
      prg_data_r <= prg_data_s;
      chr_wren_r <= chr_wren_s;
      chr_addr_r <= chr_addr_s;
      chr_data_r <= chr_data_s;
      done_r     <= done_s;
      error_r    <= error_s;
      code_r     <= code_s;
      hold_r     <= hold_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign prgmr_wren = prg_wren_r;
  assign prgmr_addr = prg_addr_r;
  assign prgmr_data = prg_data_r;
  assign chr_wren   = chr_wren_r;
  assign chr_addr   = chr_addr_r;
  assign chr_data   = chr_data_r;
  assign cpu_hold   = hold_r;
  assign done       = done_r;
  assign error      = error_r;
  assign error_code = code_r;
  assign mirroring  = mirroring_s;

endmodule
